// File: rtl/mult_seq.sv
// Iterative unsigned shift-and-add multiplier: one add-and-shift step per clock,
// driving a 32-bit ripple adder for the partial product.

module adder (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Cout
);
    logic [32:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign Sum[i]  = A[i] ^ B[i] ^ c[i];
        assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[32];
endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; registers hold
// RUN   | one add/shift iteration per cycle, cnt counts 0..n-1
// DONE  | product freshly loaded, done asserted for this one cycle
module mult_seq #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*n-1:0] product
);
    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [n-1:0]   m;
    logic [2*n-1:0] p;
    logic [CW-1:0]  cnt;

    logic [n-1:0]   sum;
    logic           cout;
    logic [2*n-1:0] p_next;

    adder u_adder (
        .A    (p[2*n-1:n]),
        .B    (m),
        .Cin  (1'b0),
        .Sum  (sum),
        .Cout (cout)
    );

    // The adder carry lands in the top bit so the shifted result never overflows.
    always_comb begin
        p_next = {1'b0, p[2*n-1:1]};
        if (p[0])
            p_next = {cout, sum, p[n-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            p       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= a;
                        p     <= {{n{1'b0}}, b};
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(n - 1)) begin
                        product <= p_next;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: a timing/arithmetic model checked every cycle plus
// directed operations with hand-computed products.

module tb_mult_seq;
    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic [63:0]   product;

    int total = 0;
    int bad   = 0;

    mult_seq #(.n(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start yields n busy cycles, then a done cycle with product = a*b.
    int          m_left;
    logic        m_done;
    logic [63:0] m_prod;
    logic [63:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_pend <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_prod <= m_pend;
            end
        end else if (start) begin
            m_left <= N;
            m_pend <= 64'(a) * 64'(b);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_busy", {63'b0, busy}, {63'b0, (m_left > 0)});
            chk("model_done", {63'b0, done}, {63'b0, m_done});
            chk("model_product", product, m_prod);
        end
    end

    int busy_cycles;
    always @(negedge clk) begin
        if (busy) busy_cycles++;
    end

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wait_done: done never rose within %0d cycles", cycles);
        end
    endtask

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                          input logic [63:0] exp, input string name);
        int cyc;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk(name, product, exp);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int gap;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_product", product, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic multiply with busy-length check and hold afterwards.
        @(negedge clk);
        a = 32'd3; b = 32'd5; start = 1'b1; busy_cycles = 0;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("basic_product", product, 64'h0000_0000_0000_000F);
        chk("basic_busy_len", 64'(busy_cycles), 64'd32);
        repeat (5) @(negedge clk);
        chk("basic_hold", product, 64'h0000_0000_0000_000F);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "carry_max");
        run_op(32'h0, 32'hDEAD_BEEF, 64'h0, "zero");
        run_op(32'h1234_5678, 32'h1, 64'h0000_0000_1234_5678, "identity");
        run_op(32'h1, 32'h8000_0000, 64'h0000_0000_8000_0000, "msb");
        run_op(32'hDEAD_BEEF, 32'h0001_0000, 64'h0000_DEAD_BEEF_0000, "shift16");

        // Ignored start during RUN and DONE.
        @(negedge clk);
        a = 32'd7; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("ignore_product", product, 64'd42);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore_no_rerun", {63'b0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("ignore_idle_busy", {63'b0, busy}, 64'd0);
        chk("ignore_idle_done", {63'b0, done}, 64'd0);
        chk("ignore_hold", product, 64'd42);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        a = 32'd100; b = 32'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        chk("midrst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd100, 32'd200, 64'd20000, "after_reset");

        // Back-to-back with start held high.
        @(negedge clk);
        a = 32'd2; b = 32'd3; start = 1'b1;
        @(negedge clk);
        wait_done(cyc);
        chk("b2b_first", product, 64'd6);
        a = 32'd4; b = 32'd5;
        @(negedge clk);
        gap = 1;
        while (!done && gap < 60) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        chk("b2b_second", product, 64'd20);
        chk("b2b_spacing", 64'(gap), 64'd34);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mult_seq.md
# mult_seq

Iterative unsigned shift-and-add multiplier built around the team's 32-bit ripple `adder` (ports A, B, Cin, Sum, Cout). The block sits directly downstream of that adder: it drives the adder's A/B operands every cycle and consumes its Sum/Cout to form the partial product. It is the multi-cycle multiply unit for the datapath. A start/busy/done handshake runs one n-cycle operation at a time.

## Interface
- `n`, 32. Operand width. Must equal the adder width, so only 32 is supported.
- `clk`  in  1  Rising-edge clock.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Request. Sampled only in IDLE.
- `a`  in  n  Multiplicand. Captured when `start` is accepted.
- `b`  in  n  Multiplier. Captured when `start` is accepted.
- `busy`  out  1  High while iterating (RUN state).
- `done`  out  1  One-cycle pulse when `product` is updated.
- `product`  out  2n  Unsigned a*b. Registered and held until the next completion.

## Operation
- **Internal registers**
  - `M[n-1:0]`: multiplicand.
  - `P[2n-1:0]`: accumulator/multiplier pair.
  - `cnt`: iteration counter, 0..n-1, width ⌈log2 n⌉.
  - `state`: IDLE, RUN, or DONE.
- **Adder hookup:** one `adder` instance with A = `P[2n-1:n]`, B = `M`, Cin tied 0. Sum and Cout are used combinationally in the same cycle.
- **IDLE**
  - If `start`=1: load `M`←`a`, `P`←{n'b0, `b`}, `cnt`←0, go to RUN.
  - Otherwise hold all registers.
- **RUN (one iteration per cycle)**
  - If `P[0]`=1: `P`←{Cout, Sum, `P[n-1:1]`}.
  - If `P[0]`=0: `P`←{1'b0, `P[2n-1:1]`}.
  - `cnt`←`cnt`+1.
  - When `cnt`=n-1, the iteration still executes. On that same edge, `product` is loaded with the post-iteration value of `P`, and the state moves to DONE.
- **DONE:** `done`=1 for exactly this cycle. Unconditionally return to IDLE on the next edge.
- **start handling:** `start` in RUN or DONE is ignored and is not queued. A new `start` can be accepted at the earliest in the cycle after DONE (IDLE).
- **Arithmetic:** unsigned only. The carry out of the adder is never lost: Cout becomes bit 2n-1 before the shift. The result is exact for all 2^n × 2^n inputs, with no overflow.
- **product register:** changes only on the RUN→DONE edge. It does not change on `start` or in IDLE.
- **Reset (asynchronous, any state including mid-RUN)**
  - state←IDLE.
  - `M`, `P`, `cnt`, `product` ← 0.
  - `busy`=0, `done`=0.
  - A partial operation is discarded.

## Timing
- **Outputs:**
  - `busy` = (state==RUN).
  - `done` = (state==DONE).
  - Both are decoded from registered state and are glitch-free.
- **Reset values:** `busy`=0, `done`=0, `product`=0.
- **Latency:** `start` sampled high in IDLE at edge k gives the following.
  - `busy` is high from edge k through edge k+n (n cycles).
  - `done` is high from edge k+n to edge k+n+1.
  - `product` is valid from edge k+n.
  - The block returns to IDLE at edge k+n+1.
- **Throughput:** one multiply per n+2 cycles when `start` is held high continuously.
- **Input capture:** `a` and `b` only need to be stable at the accepting edge. They may change freely afterwards.
- **Critical path:** `P` register → 32-bit ripple adder → `P` register. There is no pipelining inside an iteration.

## Test plan
- **Basic multiply:** reset, then `a`=3, `b`=5, `start` for 1 cycle. Require `busy` high for exactly 32 cycles, then `done` for 1 cycle, then `product`=64'h0000_0000_0000_000F. `product` holds afterwards.
- **Carry path:** `a`=`b`=32'hFFFF_FFFF. Require `product`=64'hFFFF_FFFE_0000_0001.
- **Zero and identity:**
  - `a`=0, `b`=32'hDEAD_BEEF → 0.
  - `a`=32'h1234_5678, `b`=1 → 64'h0000_0000_1234_5678.
  - `a`=1, `b`=32'h8000_0000 → 64'h0000_0000_8000_0000.
- **Ignored start:**
  - Start `a`=7, `b`=6.
  - Pulse `start` with `a`=9, `b`=9 at RUN cycle 10 and again during DONE.
  - Require `product`=42, a single `done` pulse, and return to IDLE with no second operation.
- **Reset mid-operation:** drop `rst_n` at RUN cycle 15 of `a`=100, `b`=200 (asynchronously, between edges). Require immediately `busy`=0, `done`=0, `product`=0. After release, `a`=100, `b`=200 yields `product`=20000.
- **Back-to-back:** hold `start` high with `a`=2, `b`=3, then `a`=4, `b`=5 (changed during DONE). Require `done` pulses 34 cycles apart with products 6 then 20.
